// File: rtl/div_iter_seq.sv
// div_iter_seq: multi-cycle RV32IM DIV/DIVU/REM/REMU sequencer.
// Radix-2 restoring divider on absolute values, with sign fix-up and the
// RISC-V divide-by-zero / signed-overflow results applied at the end.
// Optional feature macro: DIV_EARLY_OUT_EN (special cases finish from PREP).
module div_iter_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int END_IDX    = DATA_WIDTH - 1,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic [DATA_WIDTH-1:0] r_divisor;

  // Iteration state
  logic [DATA_WIDTH-1:0] r_abs_divisor;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [DATA_WIDTH-1:0] r_result;

  // Combinational helpers
  logic                  w_accept;
  logic                  w_signed;
  logic                  w_sign1;
  logic                  w_sign2;
  logic [DATA_WIDTH-1:0] w_abs_1;
  logic [DATA_WIDTH-1:0] w_abs_2;
  logic                  w_div_zero;
  logic                  w_overflow;
  logic                  w_special;
  logic [DATA_WIDTH-1:0] w_special_res;
  logic [DATA_WIDTH:0]   w_shift_r;
  logic [DATA_WIDTH+1:0] w_trial;
  logic                  w_trial_neg;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;
  logic [DATA_WIDTH-1:0] w_iter_res;

  // A new request is taken only when not busy, and an abort always wins.
  assign w_accept = (r_state == S_IDLE || r_state == S_DONE) && start && !abort;

  // op[0]=0 selects the signed variants (DIV, REM).
  assign w_signed = ~r_op[0];
  assign w_sign1  = w_signed & r_dividend[END_IDX];
  assign w_sign2  = w_signed & r_divisor[END_IDX];
  assign w_abs_1  = w_sign1 ? (~r_dividend + 1'b1) : r_dividend;
  assign w_abs_2  = w_sign2 ? (~r_divisor + 1'b1) : r_divisor;

  // RISC-V special cases, evaluated on the latched operands.
  assign w_div_zero = (r_divisor == '0);
  assign w_overflow = w_signed
                    && (r_dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                    && (r_divisor == '1);
  assign w_special  = w_div_zero | w_overflow;

  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign w_special_res = r_op[1] ? (w_div_zero ? r_dividend : '0)
                                 : (w_div_zero ? '1 : r_dividend);

  // One restoring step: shift {r,q} left and try to subtract the divisor.
  // Two guard bits keep the trial sign exact for unsigned divisors near 2^W.
  assign w_shift_r   = {r_rem, r_quo[END_IDX]};
  assign w_trial     = {1'b0, w_shift_r} - {2'b00, r_abs_divisor};
  assign w_trial_neg = w_trial[DATA_WIDTH+1];

  // Sign fix-up and result selection.
  assign w_q_fix    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix    = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_iter_res = r_op[1] ? w_r_fix : w_q_fix;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_PREP;
      end
      S_PREP: begin
        busy = 1'b1;
`ifdef DIV_EARLY_OUT_EN
        w_state_next = w_special ? S_DONE : S_CALC;
`else
        w_state_next = S_CALC;
`endif
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = S_FIX;
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_PREP : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) w_state_next = S_IDLE;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op          <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_abs_divisor <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_result      <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= op;
        r_dividend <= operand_1;
        r_divisor  <= operand_2;
      end
      case (r_state)
        S_PREP: begin
          r_rem         <= '0;
          r_quo         <= w_abs_1;
          r_abs_divisor <= w_abs_2;
          r_cnt         <= CNT_W'(DATA_WIDTH);
          r_neg_q       <= w_sign1 ^ w_sign2;
          r_neg_r       <= w_sign1;
`ifdef DIV_EARLY_OUT_EN
          if (!abort && w_special) r_result <= w_special_res;
`endif
        end
        S_CALC: begin
          r_rem <= w_trial_neg ? w_shift_r[END_IDX:0] : w_trial[END_IDX:0];
          r_quo <= {r_quo[END_IDX-1:0], ~w_trial_neg};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (!abort) r_result <= w_special ? w_special_res : w_iter_res;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
